// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the clock/stage side (slave).
interface reset_sequencer_if #(
    parameter int N_STAGES = 3
);
    logic                locked;
    logic                sw_rst_req;
    logic [N_STAGES-1:0] stage_ready;
    logic [N_STAGES-1:0] rst_out;
    logic                seq_done;
    logic                fault;
    logic [2:0]          state_dbg;

    modport master (
        input  locked,
        input  sw_rst_req,
        input  stage_ready,
        output rst_out,
        output seq_done,
        output fault,
        output state_dbg
    );

    modport slave (
        output locked,
        output sw_rst_req,
        output stage_ready,
        input  rst_out,
        input  seq_done,
        input  fault,
        input  state_dbg
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: lock filter, then in-order per-stage reset release gated by stage ready.
// All outputs registered; lock loss reaches the outputs 3 cycles after the locked edge; no backpressure.
module reset_sequencer #(
    parameter int N_STAGES      = 3,
    parameter int LOCK_FILTER   = 16,
    parameter int STAGE_HOLD    = 8,
    parameter int READY_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    reset_sequencer_if.master bus
);
    localparam int                  IDX_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [CNT_W-1:0]    LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(STAGE_HOLD - 1);
    localparam logic [CNT_W-1:0]    RDY_LAST  = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]    K_LAST    = IDX_W'(N_STAGES - 1);
    localparam logic [IDX_W-1:0]    K_ONE     = IDX_W'(1);
    localparam logic [N_STAGES-1:0] ALL_RST   = '1;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_RELEASE   = 3'd1,
        S_WAIT_RDY  = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDX_W-1:0]    k;
    logic [IDX_W-1:0]    k_nxt;
    logic                lock_meta;
    logic                locked_s;
    logic                abort;
    logic                rdy_k;
    logic [N_STAGES-1:0] rst_q;
    logic [N_STAGES-1:0] rst_nxt;
    logic                done_q;
    logic                done_nxt;
    logic                fault_q;
    logic                fault_nxt;
    logic [2:0]          dbg_q;

    assign abort         = !locked_s || bus.sw_rst_req;
    assign rdy_k         = bus.stage_ready[k];
    assign bus.rst_out   = rst_q;
    assign bus.seq_done  = done_q;
    assign bus.fault     = fault_q;
    assign bus.state_dbg = dbg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            k         <= '0;
            rst_q     <= ALL_RST;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            dbg_q     <= 3'd0;
        end else begin
            lock_meta <= bus.locked;
            locked_s  <= lock_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            k         <= k_nxt;
            rst_q     <= rst_nxt;
            done_q    <= done_nxt;
            fault_q   <= fault_nxt;
            dbg_q     <= state_nxt;
        end
    end

    // Abort outranks every other transition, including a ready arriving the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k;
        if (abort) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
            k_nxt     = '0;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    if (cnt == LOCK_LAST) begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = '0;
                        k_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = S_WAIT_RDY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy_k) begin
                        cnt_nxt = '0;
                        if (k == K_LAST) begin
                            state_nxt = S_RUN;
                        end else begin
                            state_nxt = S_RELEASE;
                            k_nxt     = k + K_ONE;
                        end
                    end else if (cnt == RDY_LAST) begin
                        state_nxt = S_FAULT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_RUN, S_FAULT: begin
                    state_nxt = state;
                end
                default: begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                    k_nxt     = '0;
                end
            endcase
        end
    end

    always_comb begin
        rst_nxt   = rst_q;
        done_nxt  = (state_nxt == S_RUN);
        fault_nxt = (state_nxt == S_FAULT);
        if (state_nxt == S_WAIT_LOCK || state_nxt == S_FAULT) begin
            rst_nxt = ALL_RST;
        end else if (state == S_RELEASE && state_nxt == S_WAIT_RDY) begin
            rst_nxt[k] = 1'b0;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing scenarios plus randomized traffic against a timestamp model.
module tb_reset_sequencer;
    localparam int N  = 3;
    localparam int LF = 4;
    localparam int SH = 2;
    localparam int RT = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0       = 0;

    // Reference model: phase (0 lock wait, 1 holding, 2 waiting ready, 3 run, 4 fault),
    // time the phase began, next stage, number of stages released, lock delay line.
    int m_phase = 0;
    int m_since = 0;
    int m_k     = 0;
    int m_rel   = 0;
    int m_run   = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    reset_sequencer_if #(.N_STAGES(N)) bus ();

    reset_sequencer #(
        .N_STAGES(N), .LOCK_FILTER(LF), .STAGE_HOLD(SH), .READY_TIMEOUT(RT), .CNT_W(11)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_abort();
        m_phase = 0;
        m_run   = 0;
        m_k     = 0;
        m_rel   = 0;
    endtask

    task automatic model_edge();
        bit ls;
        if (!rst_n) begin
            model_abort();
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.locked;
        if (!ls || bus.sw_rst_req) begin
            model_abort();
        end else if (m_phase == 0) begin
            m_run++;
            if (m_run == LF) begin
                m_phase = 1;
                m_since = cyc;
            end
        end else if (m_phase == 1) begin
            if (cyc - m_since == SH) begin
                m_rel   = m_k + 1;
                m_phase = 2;
                m_since = cyc;
            end
        end else if (m_phase == 2) begin
            if (bus.stage_ready[m_k]) begin
                if (m_k == N - 1) begin
                    m_phase = 3;
                end else begin
                    m_k++;
                    m_phase = 1;
                    m_since = cyc;
                end
            end else if (cyc - m_since == RT) begin
                m_phase = 4;
                m_rel   = 0;
            end
        end
    endtask

    function automatic logic [2:0] exp_rst();
        logic [2:0] ones;
        ones = 3'b111;
        if (m_phase == 4) return ones;
        return ones << m_rel;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("model_rst_out",   32'(bus.rst_out),   32'(exp_rst()));
        check("model_seq_done",  32'(bus.seq_done),  32'(m_phase == 3));
        check("model_fault",     32'(bus.fault),     32'(m_phase == 4));
        check("model_state_dbg", 32'(bus.state_dbg), 32'(m_phase));
    endtask

    task automatic go(input int t);
        while (cyc - t0 < t) step();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.locked      = 1'b1;
        bus.sw_rst_req  = 1'b0;
        bus.stage_ready = 3'b111;

        // Reset state
        repeat (5) step();
        check("reset_rst_out",   32'(bus.rst_out),   32'(3'b111));
        check("reset_seq_done",  32'(bus.seq_done),  32'(1'b0));
        check("reset_fault",     32'(bus.fault),     32'(1'b0));
        check("reset_state_dbg", 32'(bus.state_dbg), 32'(3'd0));

        // Clean sequence with all stages ready
        rst_n = 1'b1;
        t0 = cyc;
        go(7);  check("s2_r0_before", 32'(bus.rst_out), 32'(3'b111));
        go(8);  check("s2_r0_fall",   32'(bus.rst_out), 32'(3'b110));
        go(10); check("s2_r1_before", 32'(bus.rst_out), 32'(3'b110));
        go(11); check("s2_r1_fall",   32'(bus.rst_out), 32'(3'b100));
        go(13); check("s2_r2_before", 32'(bus.rst_out), 32'(3'b100));
        go(14); check("s2_r2_fall",   32'(bus.rst_out), 32'(3'b000));
                check("s2_done_early", 32'(bus.seq_done), 32'(1'b0));
        go(15); check("s2_done",      32'(bus.seq_done), 32'(1'b1));
                check("s2_state_run", 32'(bus.state_dbg), 32'(3'd3));

        // One-cycle lock glitch restarts the filter
        hard_reset();
        rst_n = 1'b1;
        t0 = cyc;
        go(3);  bus.locked = 1'b0;
        go(4);  bus.locked = 1'b1;
        go(11); check("s3_r0_held", 32'(bus.rst_out), 32'(3'b111));
        go(12); check("s3_r0_fall", 32'(bus.rst_out), 32'(3'b110));

        // Stage 1 never ready -> timeout fault, then software resequence
        hard_reset();
        bus.stage_ready = 3'b101;
        rst_n = 1'b1;
        t0 = cyc;
        go(18); check("s4_no_fault_yet", 32'(bus.fault), 32'(1'b0));
                check("s4_rst_mid",      32'(bus.rst_out), 32'(3'b100));
        go(19); check("s4_fault",        32'(bus.fault), 32'(1'b1));
                check("s4_rst_all",      32'(bus.rst_out), 32'(3'b111));
                check("s4_state_fault",  32'(bus.state_dbg), 32'(3'd4));
        go(21); bus.sw_rst_req = 1'b1; bus.stage_ready = 3'b111;
        go(22); bus.sw_rst_req = 1'b0;
                check("s4_fault_clr",    32'(bus.fault), 32'(1'b0));
                check("s4_state_wait",   32'(bus.state_dbg), 32'(3'd0));
        go(27); check("s4_reseq_held",   32'(bus.rst_out), 32'(3'b111));
        go(28); check("s4_reseq_fall",   32'(bus.rst_out), 32'(3'b110));
        go(34); check("s4_done_early",   32'(bus.seq_done), 32'(1'b0));
        go(35); check("s4_done",         32'(bus.seq_done), 32'(1'b1));

        // Lock loss while running, then full resequence
        go(40); bus.locked = 1'b0;
        go(42); check("s5_still_run",  32'(bus.seq_done), 32'(1'b1));
                check("s5_still_rel",  32'(bus.rst_out), 32'(3'b000));
        go(43); check("s5_abort_rst",  32'(bus.rst_out), 32'(3'b111));
                check("s5_abort_done", 32'(bus.seq_done), 32'(1'b0));
        go(45); bus.locked = 1'b1;
        t0 = cyc;
        go(8);  check("s5_r0_fall", 32'(bus.rst_out), 32'(3'b110));
        go(11); check("s5_r1_fall", 32'(bus.rst_out), 32'(3'b100));
        go(14); check("s5_r2_fall", 32'(bus.rst_out), 32'(3'b000));
        go(15); check("s5_done",    32'(bus.seq_done), 32'(1'b1));

        // Software abort coinciding with the last stage becoming ready
        hard_reset();
        bus.stage_ready = 3'b011;
        rst_n = 1'b1;
        t0 = cyc;
        go(16); bus.sw_rst_req = 1'b1; bus.stage_ready = 3'b111;
        go(17); bus.sw_rst_req = 1'b0;
                check("s6_state_wait", 32'(bus.state_dbg), 32'(3'd0));
                check("s6_no_done",    32'(bus.seq_done), 32'(1'b0));
                check("s6_rst_all",    32'(bus.rst_out), 32'(3'b111));
        go(18); check("s6_no_done_after", 32'(bus.seq_done), 32'(1'b0));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n          = ($urandom_range(0, 599) != 0);
            bus.sw_rst_req = ($urandom_range(0, 119) == 0);
            if (bus.locked) bus.locked = ($urandom_range(0, 149) != 0);
            else            bus.locked = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < N; b++) bus.stage_ready[b] = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
